// File: rtl/apsk_pkg.sv
// Shared definitions for the APSK demapper control path.
// Provides the mode encodings, per-mode lane counts, the metric-unit latency,
// the controller state type and the mode-to-lane-mask helper.
package apsk_pkg;

  localparam int unsigned SYM_NUM  = 64;
  localparam int unsigned MCU_LAT  = 4;
  localparam int unsigned LANES_16 = 16;
  localparam int unsigned LANES_32 = 32;
  localparam int unsigned LANES_64 = 64;

  typedef enum logic [1:0] {
    MODE_16  = 2'd0,
    MODE_32  = 2'd1,
    MODE_64  = 2'd2,
    MODE_RSV = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StSwitch
  } ctrl_state_e;

  // Lanes beyond the active constellation size are cleared; the reserved
  // encoding never reaches the LUT bank, so it just maps to the full mask.
  function automatic logic [SYM_NUM-1:0] mode_to_mask(input logic [1:0] mode);
    logic [SYM_NUM-1:0] mask;
    case (mode)
      MODE_16: mask = {{(SYM_NUM - LANES_16){1'b0}}, {LANES_16{1'b1}}};
      MODE_32: mask = {{(SYM_NUM - LANES_32){1'b0}}, {LANES_32{1'b1}}};
      default: mask = {LANES_64{1'b1}};
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mmcu_valid_pipe.sv
// Valid + mode shift register mirroring the fixed latency of the metric array.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   valid_i/mode_i: symbol entering the array this cycle and its mode
//   valid_o/mode_o: metrics of that symbol leave the array this cycle
//   empty_o       : no symbol anywhere in the pipe
module mmcu_valid_pipe #(
  parameter int unsigned Depth = 5,
  parameter int unsigned ModeW = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [ModeW-1:0] mode_i,
  output logic             valid_o,
  output logic [ModeW-1:0] mode_o,
  output logic             empty_o
);

  logic [Depth-1:0] valid_q;
  logic [ModeW-1:0] mode_q [Depth];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mode_q[i] <= '0;
      end
    end else begin
      valid_q   <= {valid_q[Depth-2:0], valid_i};
      mode_q[0] <= mode_i;
      for (int i = 1; i < int'(Depth); i++) begin
        mode_q[i] <= mode_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign mode_o  = mode_q[Depth-1];
  assign empty_o = ~|valid_q;

endmodule

// File: rtl/mmcu_ctrl.sv
// Sequencer in front of the 64-lane APSK metric computation array.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   in_valid/in_ready               : symbol handshake (in_ready is combinational)
//   in_u_re, in_u_im, in_h, in_mode : equalised symbol, channel gain and mode
//   w_u_re, w_u_im, w_h             : registered operands shared by all lanes
//   lut_sel, sym_mask               : constellation bank and active-lane mask
//   metric_valid, metric_mode       : array output strobe aligned to its latency
//   sym_cnt                         : accepted-symbol count (wraps)
//   busy, err_mode                  : activity flag, reserved-mode drop pulse
module mmcu_ctrl #(
  parameter int unsigned wordlength = 18,
  parameter int unsigned MCU_LAT    = apsk_pkg::MCU_LAT,
  parameter int unsigned sym_num    = apsk_pkg::SYM_NUM,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [wordlength-1:0] in_u_re,
  input  logic [wordlength-1:0] in_u_im,
  input  logic [wordlength-1:0] in_h,
  input  logic [1:0]            in_mode,
  output logic [wordlength-1:0] w_u_re,
  output logic [wordlength-1:0] w_u_im,
  output logic [wordlength-1:0] w_h,
  output logic [1:0]            lut_sel,
  output logic [sym_num-1:0]    sym_mask,
  output logic                  metric_valid,
  output logic [1:0]            metric_mode,
  output logic [CNT_W-1:0]      sym_cnt,
  output logic                  busy,
  output logic                  err_mode
);
  import apsk_pkg::*;

  ctrl_state_e           state_q, state_d;
  logic [wordlength-1:0] w_u_re_q, w_u_re_d, w_u_im_q, w_u_im_d, w_h_q, w_h_d;
  logic [1:0]            lut_sel_q, lut_sel_d;
  logic [sym_num-1:0]    sym_mask_q, sym_mask_d;
  logic [CNT_W-1:0]      sym_cnt_q, sym_cnt_d;
  logic                  err_q, err_d;
  logic                  pipe_empty;
  logic                  mode_rsv, mode_chg, accept, acc_sym;

  assign mode_rsv = (in_mode == MODE_RSV);
  assign mode_chg = in_valid & ~mode_rsv & (in_mode != lut_sel_q);
  // Gated by rst_n so the handshake is closed while reset is applied.
  assign in_ready = rst_n & ((state_q == StIdle) | (state_q == StRun))
                  & ((in_mode == lut_sel_q) | mode_rsv);
  assign accept   = in_valid & in_ready;
  assign acc_sym  = accept & ~mode_rsv;

  always_comb begin
    state_d    = state_q;
    w_u_re_d   = w_u_re_q;
    w_u_im_d   = w_u_im_q;
    w_h_d      = w_h_q;
    lut_sel_d  = lut_sel_q;
    sym_mask_d = sym_mask_q;
    sym_cnt_d  = sym_cnt_q;
    err_d      = accept & mode_rsv;

    if (acc_sym) begin
      w_u_re_d  = in_u_re;
      w_u_im_d  = in_u_im;
      w_h_d     = in_h;
      sym_cnt_d = sym_cnt_q + CNT_W'(1);
    end

    case (state_q)
      StIdle: begin
        // Pipe is always empty here, so a new bank can be loaded at once.
        if (mode_chg) begin
          state_d    = StSwitch;
          lut_sel_d  = in_mode;
          sym_mask_d = mode_to_mask(in_mode);
        end else if (acc_sym) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (mode_chg) begin
          state_d = StDrain;
        end else if (!acc_sym && pipe_empty) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        // The mode is sampled only when leaving DRAIN; earlier requests are ignored.
        if (pipe_empty) begin
          state_d = StSwitch;
          if (in_valid && !mode_rsv) begin
            lut_sel_d  = in_mode;
            sym_mask_d = mode_to_mask(in_mode);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      w_u_re_q   <= '0;
      w_u_im_q   <= '0;
      w_h_q      <= '0;
      lut_sel_q  <= MODE_64;
      sym_mask_q <= '1;
      sym_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_u_re_q   <= w_u_re_d;
      w_u_im_q   <= w_u_im_d;
      w_h_q      <= w_h_d;
      lut_sel_q  <= lut_sel_d;
      sym_mask_q <= sym_mask_d;
      sym_cnt_q  <= sym_cnt_d;
      err_q      <= err_d;
    end
  end

  // One stage for the operand register plus MCU_LAT stages inside the array.
  mmcu_valid_pipe #(
    .Depth (MCU_LAT + 1),
    .ModeW (2)
  ) u_valid_pipe (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (acc_sym),
    .mode_i  (in_mode),
    .valid_o (metric_valid),
    .mode_o  (metric_mode),
    .empty_o (pipe_empty)
  );

  assign w_u_re   = w_u_re_q;
  assign w_u_im   = w_u_im_q;
  assign w_h      = w_h_q;
  assign lut_sel  = lut_sel_q;
  assign sym_mask = sym_mask_q;
  assign sym_cnt  = sym_cnt_q;
  assign err_mode = err_q;
  assign busy     = (state_q != StIdle) | ~pipe_empty;

endmodule
